// File: rtl/xclk_bundle_tx_if.sv
// ---------------------------------------------------------------------------
// xclk_bundle_tx_if
//   Groups the producer-side valid/ready word port and the far-domain
//   bundled-data req/ack port of xclk_bundle_tx.
//   slave  : seen by the controller (xclk_bundle_tx)
//   master : seen by whatever drives the producer side and models the receiver
// Signals
//   s_valid_i / s_data_i / s_ready_o : producer word handshake
//   x_req_o / x_data_o / x_ack_i     : 4-phase bundled-data handshake
//   done_o                           : one-cycle transfer-complete pulse
//   err_o / clr_i                    : timeout flag and its clear
// ---------------------------------------------------------------------------
interface xclk_bundle_tx_if #(
    parameter int WIDTH = 10
);
    logic             s_valid_i;
    logic [WIDTH-1:0] s_data_i;
    logic             s_ready_o;
    logic             x_req_o;
    logic [WIDTH-1:0] x_data_o;
    logic             x_ack_i;
    logic             done_o;
    logic             err_o;
    logic             clr_i;

    modport slave (
        input  s_valid_i, s_data_i, x_ack_i, clr_i,
        output s_ready_o, x_req_o, x_data_o, done_o, err_o
    );

    modport master (
        output s_valid_i, s_data_i, x_ack_i, clr_i,
        input  s_ready_o, x_req_o, x_data_o, done_o, err_o
    );
endinterface

// File: rtl/xclk_bundle_tx.sv
// ---------------------------------------------------------------------------
// xclk_bundle_tx
//   Source side of a bundled-data clock-domain crossing. A word accepted from
//   a valid/ready producer is registered onto x_data_o and held stable while a
//   4-phase req/ack handshake runs with the far domain. x_ack_i is asynchronous
//   and only its synchronised copy (ack_s) is used by the FSM. A per-phase
//   timeout parks the controller in ERR when the receiver is dead.
// Ports
//   clk_i  : source-domain clock
//   rst_ni : asynchronous active-low reset
//   bus    : xclk_bundle_tx_if.slave (producer port, far-domain port,
//            done_o pulse, err_o flag, clr_i)
// ---------------------------------------------------------------------------
module xclk_bundle_tx #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    xclk_bundle_tx_if.slave    bus
);

    localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    logic                   ack_s;
    logic                   s_ready;
    logic                   timeout_hit;
    logic [CNT_W-1:0]       cnt_inc;

    // Synchroniser: shift x_ack_i in at bit 0; the MSB is the only copy used.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.x_ack_i};
    end

    assign ack_s       = sync_q[SYNC_STAGES-1];
    assign s_ready     = (state_q == IDLE);
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);
    // Saturating increment so a disabled timeout never wraps the counter.
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.s_valid_i && s_ready) begin
                    data_d  = bus.s_data_i;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                // Ack is checked first so it beats a timeout in the same cycle.
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            REL: begin
                cnt_d = cnt_inc;
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            ERR: begin
                req_d = 1'b0;
                // Leave only once the receiver has released ack, otherwise the
                // next request would be mistaken as acknowledged at once.
                if (bus.clr_i && !ack_s) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
        end
    end

    assign bus.s_ready_o = s_ready;
    assign bus.x_req_o   = req_q;
    assign bus.x_data_o  = data_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_xclk_bundle_tx.sv
// ---------------------------------------------------------------------------
// tb_xclk_bundle_tx
//   Directed bench for xclk_bundle_tx. dut_a (TIMEOUT_CYC=8) covers reset,
//   single word, streaming, both timeouts, clear and ack-vs-timeout priority;
//   dut_z (TIMEOUT_CYC=0) covers the disabled timeout.
// ---------------------------------------------------------------------------
module tb_xclk_bundle_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    xclk_bundle_tx_if #(.WIDTH(10)) bus_a ();
    xclk_bundle_tx_if #(.WIDTH(10)) bus_z ();

    xclk_bundle_tx #(.WIDTH(10), .SYNC_STAGES(2), .TIMEOUT_CYC(8)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_a.slave)
    );

    xclk_bundle_tx #(.WIDTH(10), .SYNC_STAGES(2), .TIMEOUT_CYC(0)) dut_z (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_z.slave)
    );

    // Receiver model for dut_a: instant (ack follows req) or driven directly.
    logic inst_mode = 1'b0;
    logic ack_drv   = 1'b0;
    assign bus_a.x_ack_i = inst_mode ? bus_a.x_req_o : ack_drv;
    assign bus_z.x_ack_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_a(input logic [9:0] w);
        bus_a.s_valid_i = 1'b1;
        bus_a.s_data_i  = w;
        tick();
        bus_a.s_valid_i = 1'b0;
    endtask

    initial begin
        int req_cnt, done_cnt, done_at, data_bad, ndone, nacc, last_done, cyc;
        logic prev_req, was_ready;
        logic [9:0] prev_data;
        logic [9:0] log_q[$];

        bus_a.s_valid_i = 1'b0;
        bus_a.s_data_i  = '0;
        bus_a.clr_i     = 1'b0;
        bus_z.s_valid_i = 1'b0;
        bus_z.s_data_i  = '0;
        bus_z.clr_i     = 1'b0;

        // ---- reset state ----
        repeat (2) tick();
        chk("rst_req",   bus_a.x_req_o,   0);
        chk("rst_ready", bus_a.s_ready_o, 1);
        chk("rst_err",   bus_a.err_o,     0);
        chk("rst_data",  bus_a.x_data_o,  0);
        chk("rst_done",  bus_a.done_o,    0);
        rst_n = 1'b1;
        repeat (2) tick();

        // ---- single word, receiver one cycle behind ----
        accept_a(10'h2A5);
        chk("t2_req0",   bus_a.x_req_o,   1);
        chk("t2_data0",  bus_a.x_data_o,  10'h2A5);
        chk("t2_ready0", bus_a.s_ready_o, 0);
        req_cnt = 1; done_cnt = 0; done_at = -1; data_bad = 0; prev_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            ack_drv = prev_req;
            prev_req = bus_a.x_req_o;
            if (bus_a.x_req_o) req_cnt++;
            if (bus_a.done_o) begin
                done_cnt++;
                done_at = k;
            end
            if (done_at < 0 && bus_a.x_data_o != 10'h2A5) data_bad++;
        end
        chk("t2_req_len",   req_cnt,  4);
        chk("t2_done_cnt",  done_cnt, 1);
        chk("t2_done_at",   done_at,  8);
        chk("t2_data_hold", data_bad, 0);
        ack_drv = 1'b0;

        // ---- stream 0x001..0x010, instant receiver ----
        inst_mode = 1'b1;
        bus_a.s_valid_i = 1'b1;
        bus_a.s_data_i  = 10'h001;
        ndone = 0; nacc = 0; last_done = -1; data_bad = 0;
        prev_req = bus_a.x_req_o; prev_data = bus_a.x_data_o;
        for (cyc = 0; cyc < 400 && ndone < 16; cyc++) begin
            was_ready = bus_a.s_ready_o;
            tick();
            if (was_ready && bus_a.s_valid_i) begin
                nacc++;
                if (nacc == 16) bus_a.s_valid_i = 1'b0;
                else bus_a.s_data_i = 10'(nacc + 1);
            end
            if (bus_a.x_req_o && !prev_req) log_q.push_back(bus_a.x_data_o);
            if (bus_a.x_req_o && prev_req && bus_a.x_data_o != prev_data) data_bad++;
            if (bus_a.done_o) begin
                if (last_done >= 0) chk("t3_spacing", cyc - last_done, 7);
                last_done = cyc;
                ndone++;
            end
            prev_req = bus_a.x_req_o;
            prev_data = bus_a.x_data_o;
        end
        chk("t3_done_cnt",  ndone,        16);
        chk("t3_log_len",   log_q.size(), 16);
        chk("t3_data_hold", data_bad,     0);
        for (int i = 0; i < 16; i++) begin
            if (i < log_q.size()) chk("t3_log", log_q[i], i + 1);
        end
        repeat (3) tick();
        inst_mode = 1'b0;
        ack_drv = 1'b0;
        tick();

        // ---- REQ timeout, ack stuck 0 ----
        accept_a(10'h0F0);
        repeat (7) tick();
        chk("t4_req_e7", bus_a.x_req_o, 1);
        chk("t4_err_e7", bus_a.err_o,   0);
        tick();
        chk("t4_err_e8",   bus_a.err_o,     1);
        chk("t4_req_e8",   bus_a.x_req_o,   0);
        chk("t4_ready_e8", bus_a.s_ready_o, 0);
        bus_a.clr_i = 1'b1;
        tick();
        bus_a.clr_i = 1'b0;
        chk("t4_clr_err",   bus_a.err_o,     0);
        chk("t4_clr_ready", bus_a.s_ready_o, 1);
        tick();

        // ---- REL timeout, ack stuck 1 ----
        accept_a(10'h11E);
        tick();
        ack_drv = 1'b1;
        repeat (3) tick();
        chk("t5_req_e4", bus_a.x_req_o, 0);
        chk("t5_err_e4", bus_a.err_o,   0);
        repeat (7) tick();
        chk("t5_err_e11", bus_a.err_o, 0);
        tick();
        chk("t5_err_e12", bus_a.err_o, 1);
        bus_a.clr_i = 1'b1;
        repeat (3) tick();
        chk("t5_clr_held", bus_a.err_o, 1);
        ack_drv = 1'b0;
        repeat (2) tick();
        chk("t5_clr_sync", bus_a.err_o,     1);
        chk("t5_rdy_sync", bus_a.s_ready_o, 0);
        tick();
        chk("t5_clr_done", bus_a.err_o,     0);
        chk("t5_rdy_done", bus_a.s_ready_o, 1);
        bus_a.clr_i = 1'b0;
        tick();

        // ---- ack on the exact timeout cycle ----
        accept_a(10'h0C3);
        repeat (5) tick();
        ack_drv = 1'b1;
        repeat (2) tick();
        chk("t6_req_e7", bus_a.x_req_o, 1);
        tick();
        chk("t6_req_e8",   bus_a.x_req_o,   0);
        chk("t6_err_e8",   bus_a.err_o,     0);
        chk("t6_ready_e8", bus_a.s_ready_o, 0);
        ack_drv = 1'b0;
        repeat (3) tick();
        chk("t6_done", bus_a.done_o, 1);
        chk("t6_err",  bus_a.err_o,  0);
        tick();

        // ---- asynchronous reset mid-REQ ----
        accept_a(10'h155);
        repeat (2) tick();
        chk("t1_req_pre", bus_a.x_req_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_req",   bus_a.x_req_o,   0);
        chk("t1_ready", bus_a.s_ready_o, 1);
        chk("t1_err",   bus_a.err_o,     0);
        chk("t1_data",  bus_a.x_data_o,  0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- timeout disabled, ack stuck 0 ----
        bus_z.s_valid_i = 1'b1;
        bus_z.s_data_i  = 10'h3FF;
        tick();
        bus_z.s_valid_i = 1'b0;
        repeat (5000) tick();
        chk("tz_req",   bus_z.x_req_o,   1);
        chk("tz_err",   bus_z.err_o,     0);
        chk("tz_ready", bus_z.s_ready_o, 0);
        chk("tz_data",  bus_z.x_data_o,  10'h3FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
